dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port data-memory arbiter. The processor core and the
//               program-loader/debug port share one fixed-latency memory.
//               Simultaneous requests alternate round-robin. The core is
//               stalled through pcen until its own access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
   parameter int LAT = 2                     // memory read latency, 1..15
) (
   input  logic        clk,
   input  logic        rst_n,
   // core port
   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        core_done,
   // loader / debug port
   input  logic        ld_req,
   input  logic        ld_we,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_wdata,
   output logic [31:0] ld_rdata,
   output logic        ld_done,
   // processor stall
   output logic        pcen,
   // memory port
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic       c_own_core = 1'b0;
   localparam logic       c_own_ld   = 1'b1;
   localparam logic [3:0] c_lat      = 4'(LAT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_owner;        // requester currently granted
   logic        r_last;         // requester served most recently
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_cnt;          // cycles spent in ACCESS
   logic [31:0] r_core_rdata;
   logic [31:0] r_ld_rdata;

   logic        w_any_req;
   logic        w_grant_ld;

   assign w_any_req = core_req | ld_req;

   // Pick the winner: a lone request wins; a tie goes to whoever was not served last.
   always_comb begin
      w_grant_ld = ld_req;
      if (core_req && ld_req) begin
         w_grant_ld = (r_last == c_own_core);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and memory/done outputs; outputs forced low while in reset.
   always_comb begin
      w_state_nxt = r_state;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;
      core_done   = 1'b0;
      ld_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (r_cnt == c_lat) begin
               w_state_nxt = S_RESP;
            end
            mem_en    = (r_cnt == 4'd0);
            mem_we    = r_we && (r_cnt == 4'd0);
            mem_addr  = r_addr;
            mem_wdata = r_wdata;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
            core_done   = (r_owner == c_own_core);
            ld_done     = (r_owner == c_own_ld);
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (!rst_n) begin
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = 32'h0;
         mem_wdata = 32'h0;
         core_done = 1'b0;
         ld_done   = 1'b0;
      end
   end

   // Latch the granted request, count access cycles, capture read data, track fairness.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= 4'd0;
         r_owner      <= c_own_core;
         r_last       <= c_own_ld;
         r_we         <= 1'b0;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_core_rdata <= 32'h0;
         r_ld_rdata   <= 32'h0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // ACCESS is only ever entered from IDLE, so clearing here clears on entry.
               r_cnt <= 4'd0;
               if (w_any_req) begin
                  r_owner <= w_grant_ld;
                  r_we    <= w_grant_ld ? ld_we    : core_we;
                  r_addr  <= w_grant_ld ? ld_addr  : core_addr;
                  r_wdata <= w_grant_ld ? ld_wdata : core_wdata;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + 4'd1;
               if ((r_cnt == c_lat) && !r_we) begin
                  if (r_owner == c_own_ld) begin
                     r_ld_rdata <= mem_rdata;
                  end else begin
                     r_core_rdata <= mem_rdata;
                  end
               end
            end
            S_RESP: begin
               r_last <= r_owner;
            end
            default: begin
               r_cnt <= 4'd0;
            end
         endcase
      end
   end

   assign core_rdata = r_core_rdata;
   assign ld_rdata   = r_ld_rdata;

   // The core runs only when it is not asking for memory or its own access is completing.
   assign pcen = rst_n & (~core_req | ((r_state == S_RESP) & (r_owner == c_own_core)));

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a scoreboard of
//               expected completions and a fixed-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int LAT = 2;
   localparam int GAP = 2 + LAT + 1;        // cycles between consecutive done pulses

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req, core_we, ld_req, ld_we;
   logic [31:0] core_addr, core_wdata, ld_addr, ld_wdata;
   logic [31:0] core_rdata, ld_rdata;
   logic        core_done, ld_done, pcen;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic        owner_ld;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];

   dmem_arbiter #(.LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_done  (core_done),
      .ld_req     (ld_req),
      .ld_we      (ld_we),
      .ld_addr    (ld_addr),
      .ld_wdata   (ld_wdata),
      .ld_rdata   (ld_rdata),
      .ld_done    (ld_done),
      .pcen       (pcen),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic exp_t mk(input logic o, input logic [31:0] d);
      exp_t e;
      e.owner_ld = o;
      e.rdata    = d;
      return e;
   endfunction

   // Fixed-latency read pipeline; cycles without a read return a poison word.
   logic [31:0] rd_pipe [LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= (mem_en && !mem_we) ? mem_val(mem_addr) : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // The two done outputs must never be high together.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         total++;
         if (core_done && ld_done) begin
            bad++;
            $display("FAIL both_done cyc=%0d: core_done=%b ld_done=%b, required not both", cyc, core_done, ld_done);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #4;
   endtask

   task automatic wait_done(input int maxc, output int n);
      n = 0;
      while (!(core_done || ld_done) && n < maxc) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      exp_t e;
      rst_n = 1'b0; core_req = 1'b1; ld_req = 1'b1;
      core_we = 1'b0; core_addr = 32'h100; core_wdata = 32'h0;
      ld_we = 1'b0; ld_addr = 32'h200; ld_wdata = 32'h0;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if ({core_done, ld_done, mem_en, mem_we, pcen} !== 5'b0 || mem_addr !== 32'h0 ||
             mem_wdata !== 32'h0 || core_rdata !== 32'h0 || ld_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs k=%0d: done=%b/%b en=%b we=%b pcen=%b addr=%h wdata=%h rdata=%h/%h, required all 0",
                     k, core_done, ld_done, mem_en, mem_we, pcen, mem_addr, mem_wdata, core_rdata, ld_rdata);
         end
      end
      rst_n = 1'b1;
      #1;
      total++;
      if (pcen !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_pcen: pcen=%b, required 0", pcen);
      end
      sb.push_back(mk(1'b0, mem_val(32'h100)));
      tick();
      total++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin
         bad++;
         $display("FAIL reset_first_grant: mem_en=%b addr=%h, required 1 / 00000100", mem_en, mem_addr);
      end
      ld_req = 1'b0;
      wait_done(8, n);
      total++;
      e = sb.pop_front();
      if (core_done !== 1'b1 || ld_done !== 1'b0 || n != 3 || core_rdata !== e.rdata) begin
         bad++;
         $display("FAIL reset_first_done: done=%b/%b wait=%0d rdata=%h, required 1/0 3 %h",
                  core_done, ld_done, n, core_rdata, e.rdata);
      end
      core_req = 1'b0;
   endtask

   task automatic test_ld_write();
      exp_t e;
      tick();
      core_req = 1'b0;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h20; ld_wdata = 32'h12345678;
      sb.push_back(mk(1'b1, 32'h0));     // a write leaves ld_rdata at its reset value
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++;
         if ({mem_en, mem_we, pcen, ld_done, core_done} !== {k == 1, k == 1, 1'b1, k == 4, 1'b0}) begin
            bad++;
            $display("FAIL ld_write_ctl k=%0d: en=%b we=%b pcen=%b done=%b/%b, required %b %b 1 %b/0",
                     k, mem_en, mem_we, pcen, ld_done, core_done, k == 1, k == 1, k == 4);
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
               bad++;
               $display("FAIL ld_write_data: addr=%h wdata=%h, required 00000020 12345678", mem_addr, mem_wdata);
            end
         end
         if (k == 4) begin
            e = sb.pop_front();
            total++;
            if (ld_rdata !== e.rdata) begin
               bad++;
               $display("FAIL ld_write_rdata: ld_rdata=%h, required %h", ld_rdata, e.rdata);
            end
            ld_req = 1'b0; ld_we = 1'b0;
         end
      end
   endtask

   task automatic test_round_robin();
      int n;
      int prev;
      exp_t e;
      tick();
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
      ld_req   = 1'b1; ld_we   = 1'b0; ld_addr   = 32'h80;
      sb.push_back(mk(1'b0, mem_val(32'h40)));
      sb.push_back(mk(1'b1, mem_val(32'h80)));
      sb.push_back(mk(1'b0, mem_val(32'h40)));
      sb.push_back(mk(1'b1, mem_val(32'h80)));
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         wait_done(10, n);
         total++;
         if (n >= 10) begin
            bad++;
            $display("FAIL rr_timeout i=%0d: no done within 10 cycles", i);
            core_req = 1'b0; ld_req = 1'b0;
            sb.delete();
            return;
         end
         e = sb.pop_front();
         total++;
         if ({core_done, ld_done} !== {~e.owner_ld, e.owner_ld} ||
             (e.owner_ld ? ld_rdata : core_rdata) !== e.rdata) begin
            bad++;
            $display("FAIL rr_order i=%0d: done=%b/%b rdata=%h/%h, required owner_ld=%b rdata=%h",
                     i, core_done, ld_done, core_rdata, ld_rdata, e.owner_ld, e.rdata);
         end
         if (i > 0) begin
            total++;
            if (cyc - prev != GAP) begin
               bad++;
               $display("FAIL rr_spacing i=%0d: gap=%0d, required %0d", i, cyc - prev, GAP);
            end
         end
         prev = cyc;
      end
      core_req = 1'b0; ld_req = 1'b0;
   endtask

   task automatic test_core_read();
      exp_t e;
      tick();
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
      sb.push_back(mk(1'b0, 32'hDEADBEEF));
      #1;
      total++;
      if (pcen !== 1'b0) begin
         bad++;
         $display("FAIL core_read_pcen_T: pcen=%b, required 0", pcen);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++;
         if ({mem_en, mem_we, pcen, core_done, ld_done} !== {k == 1, 1'b0, k == 4, k == 4, 1'b0}) begin
            bad++;
            $display("FAIL core_read_ctl k=%0d: en=%b we=%b pcen=%b done=%b/%b, required %b 0 %b %b/0",
                     k, mem_en, mem_we, pcen, core_done, ld_done, k == 1, k == 4, k == 4);
         end
         if (k == 1) begin
            total++;
            if (mem_addr !== 32'h10) begin
               bad++;
               $display("FAIL core_read_addr: addr=%h, required 00000010", mem_addr);
            end
         end
         if (k == 4) begin
            e = sb.pop_front();
            total++;
            if (core_rdata !== e.rdata || mem_addr !== 32'h0) begin
               bad++;
               $display("FAIL core_read_data: rdata=%h addr=%h, required %h 00000000", core_rdata, mem_addr, e.rdata);
            end
            core_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid();
      int n;
      exp_t e;
      tick();
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
      sb.push_back(mk(1'b0, mem_val(32'h30)));
      tick();                                  // cnt == 0
      total++;
      if (mem_en !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_start: mem_en=%b, required 1", mem_en);
      end
      tick();                                  // cnt == 1
      rst_n = 1'b0;
      #1;
      total++;
      if ({mem_en, core_done, pcen} !== 3'b0 || mem_addr !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid_outputs: en=%b done=%b pcen=%b addr=%h, required 0 0 0 0", mem_en, core_done, pcen, mem_addr);
      end
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if ({mem_en, core_done, ld_done, pcen} !== 4'b0 || core_rdata !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid_idle: en=%b done=%b/%b pcen=%b rdata=%h, required 0 0/0 0 00000000",
                  mem_en, core_done, ld_done, pcen, core_rdata);
      end
      tick();
      total++;
      if (mem_en !== 1'b1 || mem_addr !== 32'h30) begin
         bad++;
         $display("FAIL reset_mid_regrant: en=%b addr=%h, required 1 00000030", mem_en, mem_addr);
      end
      wait_done(8, n);
      e = sb.pop_front();
      total++;
      if (core_done !== 1'b1 || n != 3 || core_rdata !== e.rdata) begin
         bad++;
         $display("FAIL reset_mid_done: done=%b wait=%0d rdata=%h, required 1 3 %h", core_done, n, core_rdata, e.rdata);
      end
      core_req = 1'b0;
   endtask

   task automatic test_core_waits();
      exp_t e;
      tick();
      core_req = 1'b0;
      ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h50;
      sb.push_back(mk(1'b1, mem_val(32'h50)));
      sb.push_back(mk(1'b0, mem_val(32'h60)));
      // loader ACCESS from k=1, ld_done k=4, one idle cycle, core ACCESS from k=6, core_done k=9
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 1) begin
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h60;
         end
         #1;
         total++;
         if ({mem_en, pcen, ld_done, core_done} !== {(k == 1) || (k == 6), k == 9, k == 4, k == 9}) begin
            bad++;
            $display("FAIL core_waits_ctl k=%0d: en=%b pcen=%b done=%b/%b, required %b %b %b/%b",
                     k, mem_en, pcen, ld_done, core_done, (k == 1) || (k == 6), k == 9, k == 4, k == 9);
         end
         if (k == 6) begin
            total++;
            if (mem_addr !== 32'h60) begin
               bad++;
               $display("FAIL core_waits_addr: addr=%h, required 00000060", mem_addr);
            end
         end
         if ((ld_done || core_done) && sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ((e.owner_ld ? ld_rdata : core_rdata) !== e.rdata || ld_done !== e.owner_ld) begin
               bad++;
               $display("FAIL core_waits_data k=%0d: done=%b/%b rdata=%h/%h, required owner_ld=%b rdata=%h",
                        k, core_done, ld_done, core_rdata, ld_rdata, e.owner_ld, e.rdata);
            end
         end
         if (k == 4) ld_req = 1'b0;
         if (k == 9) core_req = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ld_write();
      test_round_robin();
      test_core_read();
      test_reset_mid();
      test_core_waits();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover: entries=%0d, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
